// File: rtl/reg_file.sv
// reg_file: 2R1W integer register file on duplicated 1R1W block RAM, with a post-reset clear sequencer.
// Optional macro REG_FILE_BYPASS_EN adds same-edge write-to-read forwarding.
`default_nettype none

module reg_file #(
  parameter  int WIDTH = 64,
  parameter  int NREGS = 256,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] c_LAST = AW'(NREGS - 1);

  state_t             state_q;
  logic [AW-1:0]      clr_cnt_q;
  logic               ready_q;
  logic [WIDTH-1:0]   rd_data0_q, rd_data0_d;
  logic [WIDTH-1:0]   rd_data1_q, rd_data1_d;

  // One copy per read port; both always receive the same write.
  logic [WIDTH-1:0]   mem0 [NREGS];
  logic [WIDTH-1:0]   mem1 [NREGS];

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem0[mem_waddr] <= mem_wdata;
      mem1[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_data0_d = rd_data0_q;
    rd_data1_d = rd_data1_q;
    if ((state_q == RUN) && rd_en) begin
      rd_data0_d = (rd_addr0 == '0) ? '0 : mem0[rd_addr0];
      rd_data1_d = (rd_addr1 == '0) ? '0 : mem1[rd_addr1];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (wr_addr != '0) && (rd_addr0 == wr_addr)) rd_data0_d = wr_data;
      if (wr_en && (wr_addr != '0) && (rd_addr1 == wr_addr)) rd_data1_d = wr_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
    end else begin
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == c_LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign rd_data0 = rd_data0_q;
  assign rd_data1 = rd_data1_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// Directed bench for reg_file (WIDTH=64, NREGS=256); expectations follow REG_FILE_BYPASS_EN.
`default_nettype none

module tb_reg_file;
  localparam int WIDTH = 64;
  localparam int NREGS = 256;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ready;
  logic             rd_en;
  logic [AW-1:0]    rd_addr0, rd_addr1;
  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  int errors = 0;
  int checks = 0;

  reg_file #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0;
    rd_addr0 = '0; rd_addr1 = '0; wr_addr = '0; wr_data = '0;
  endtask

  logic [WIDTH-1:0] exp_fwd0, exp_fwd1;

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_rd0", rd_data0, 64'd0);
    check("reset_rd1", rd_data1, 64'd0);

    // Release reset and issue commands throughout the clear sequence; all must be ignored.
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 64'h55;
    rd_en = 1'b1; rd_addr0 = 8'd3; rd_addr1 = 8'd3;
    for (int i = 1; i <= NREGS; i++) begin
      tick();
      if (i < NREGS) begin
        check("clear_ready_low", {63'd0, ready}, 64'd0);
        check("clear_rd0_zero", rd_data0, 64'd0);
      end
    end
    check("clear_ready_high", {63'd0, ready}, 64'd1);
    idle();

    rd_en = 1'b1; rd_addr0 = 8'd7; rd_addr1 = 8'd200;
    tick();
    check("cleared_r7", rd_data0, 64'd0);
    check("cleared_r200", rd_data1, 64'd0);
    rd_addr0 = 8'd3; rd_addr1 = 8'd3;
    tick();
    check("clear_cmd_r3_p0", rd_data0, 64'd0);
    check("clear_cmd_r3_p1", rd_data1, 64'd0);
    idle();

    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 64'h0123_4567_89AB_CDEF;
    tick();
    idle();
    rd_en = 1'b1; rd_addr0 = 8'd5; rd_addr1 = 8'd5;
    tick();
    check("rw_r5_p0", rd_data0, 64'h0123_4567_89AB_CDEF);
    check("rw_r5_p1", rd_data1, 64'h0123_4567_89AB_CDEF);
    rd_en = 1'b0; rd_addr0 = 8'd7; rd_addr1 = 8'd0;
    tick();
    check("hold_p0", rd_data0, 64'h0123_4567_89AB_CDEF);
    check("hold_p1", rd_data1, 64'h0123_4567_89AB_CDEF);

    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_en = 1'b0;
    tick();
    idle();
    rd_en = 1'b1; rd_addr0 = 8'd0; rd_addr1 = 8'd0;
    tick();
    check("r0_p0", rd_data0, 64'd0);
    check("r0_p1", rd_data1, 64'd0);
    idle();

    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 64'h10;
    tick();
    wr_data = 64'h20;
    rd_en = 1'b1; rd_addr0 = 8'd9; rd_addr1 = 8'd9;
    tick();
`ifdef REG_FILE_BYPASS_EN
    exp_fwd0 = 64'h20;
`else
    exp_fwd0 = 64'h10;
`endif
    check("same_edge_p0", rd_data0, exp_fwd0);
    check("same_edge_p1", rd_data1, exp_fwd0);
    wr_en = 1'b0;
    tick();
    check("after_write_p0", rd_data0, 64'h20);
    check("after_write_p1", rd_data1, 64'h20);

    // Ports forward independently: only port 0 matches the write address.
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 64'h30;
    rd_addr0 = 8'd9; rd_addr1 = 8'd5;
    tick();
`ifdef REG_FILE_BYPASS_EN
    exp_fwd0 = 64'h30;
`else
    exp_fwd0 = 64'h20;
`endif
    exp_fwd1 = 64'h0123_4567_89AB_CDEF;
    check("indep_p0", rd_data0, exp_fwd0);
    check("indep_p1", rd_data1, exp_fwd1);
    idle();

    wr_en = 1'b1; wr_addr = 8'd12; wr_data = 64'hAA;
    tick();
    idle();
    rd_en = 1'b1; rd_addr0 = 8'd12; rd_addr1 = 8'd12;
    tick();
    check("r12_before_rst", rd_data0, 64'hAA);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", {63'd0, ready}, 64'd0);
    check("async_rst_rd0", rd_data0, 64'd0);
    check("async_rst_rd1", rd_data1, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= NREGS; i++) begin
      tick();
      if (i == NREGS - 1) check("reclear_ready_low", {63'd0, ready}, 64'd0);
    end
    check("reclear_ready_high", {63'd0, ready}, 64'd1);
    rd_en = 1'b1; rd_addr0 = 8'd12; rd_addr1 = 8'd5;
    tick();
    check("r12_after_rst", rd_data0, 64'd0);
    check("r5_after_rst", rd_data1, 64'd0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
